// File: rtl/logic_nbit_seq_pkg.sv
// Shared types for the sliced logic unit: op codes, FSM states and sizing helpers.
package logic_nbit_seq_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_NOR   = 3'b010,
        OP_XOR   = 3'b011,
        OP_NAND  = 3'b100,
        OP_INVA  = 3'b101,
        OP_INVB  = 3'b110,
        OP_PASSA = 3'b111
    } logic_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Slice counter width; a single-slice configuration still keeps a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned ns);
        return (ns > 1) ? $clog2(ns) : 1;
    endfunction

endpackage

// File: rtl/logic_nbit_seq_if.sv
// Request/result bundle between a requester (master) and the sliced logic unit (slave).
interface logic_nbit_seq_if #(
    parameter int unsigned WIDTH = 32
);

    logic                                 start;
    logic [logic_nbit_seq_pkg::OP_W-1:0]  oprn;
    logic [WIDTH-1:0]                     a;
    logic [WIDTH-1:0]                     b;
    logic                                 busy;
    logic                                 done;
    logic [WIDTH-1:0]                     y;
    logic                                 zero;

    modport master (
        output start, oprn, a, b,
        input  busy, done, y, zero
    );

    modport slave (
        input  start, oprn, a, b,
        output busy, done, y, zero
    );

endinterface

// File: rtl/logic_nbit_seq_slice.sv
// Combinational bitwise op on one SLICE-bit chunk of the operands.
module logic_nbit_seq_slice
    import logic_nbit_seq_pkg::*;
#(
    parameter int unsigned SLICE = 8
) (
    input  logic_op_e        op_i,
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    output logic [SLICE-1:0] y_c_o
);

    always_comb begin
        y_c_o = a_i;
        case (op_i)
            OP_AND:   y_c_o = a_i & b_i;
            OP_OR:    y_c_o = a_i | b_i;
            OP_NOR:   y_c_o = ~(a_i | b_i);
            OP_XOR:   y_c_o = a_i ^ b_i;
            OP_NAND:  y_c_o = ~(a_i & b_i);
            OP_INVA:  y_c_o = ~a_i;
            OP_INVB:  y_c_o = ~b_i;
            OP_PASSA: y_c_o = a_i;
            default:  y_c_o = a_i;
        endcase
    end

endmodule

// File: rtl/logic_nbit_seq.sv
// Multi-cycle WIDTH-bit logic unit: one SLICE-bit chunk per cycle, LSB first,
// with a START/BUSY/DONE handshake and a registered result.
module logic_nbit_seq
    import logic_nbit_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic           clk,
    input  logic           rst,
    logic_nbit_seq_if.slave bus
);

    localparam int unsigned NS    = WIDTH / SLICE;
    localparam int unsigned CNT_W = cnt_width(NS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NS - 1);

    if (SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("logic_nbit_seq: WIDTH must be a non-zero multiple of SLICE");
    end

    typedef logic [NS-1:0][SLICE-1:0] slices_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic_op_e        op_q;
    slices_t          a_q, b_q, acc_q, acc_d;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             capture_c;
    logic             run_c;
    logic             last_c;
    logic [SLICE-1:0] a_sl_c, b_sl_c, y_sl_c;

    // START is only honoured when no operation is in flight.
    assign capture_c = bus.start && (state_q == ST_IDLE || state_q == ST_FIN);
    assign run_c     = (state_q == ST_RUN);
    assign last_c    = run_c && (cnt_q == CNT_LAST);

    assign a_sl_c = a_q[cnt_q];
    assign b_sl_c = b_q[cnt_q];

    logic_nbit_seq_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op_i  (op_q),
        .a_i   (a_sl_c),
        .b_i   (b_sl_c),
        .y_c_o (y_sl_c)
    );

    // Accumulator view including the slice computed this cycle.
    always_comb begin
        acc_d = acc_q;
        if (run_c) begin
            acc_d[cnt_q] = y_sl_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = capture_c ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = last_c ? ST_FIN : ST_RUN;
            ST_FIN:  state_d = capture_c ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags follow the state being entered so they register alongside it.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_RUN:  busy_d = 1'b1;
            ST_FIN:  done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Operand capture, slice stepping and the single result write on FIN entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            op_q   <= OP_AND;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            y_q    <= '0;
            zero_q <= 1'b1;
        end else begin
            if (capture_c) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                op_q  <= logic_op_e'(bus.oprn);
                cnt_q <= '0;
            end else if (run_c) begin
                acc_q <= acc_d;
                if (!last_c) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (last_c) begin
                y_q    <= acc_d;
                zero_q <= (acc_d == '0);
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;
    assign bus.zero = zero_q;

endmodule
